uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Command parser/responder for the UART command protocol.
- Consumes bytes that the UART receiver has already deframed (start bit, 8 data bits LSB-first, even parity, stop bit).
- Executes register-file writes and reads and ALU operations.
- Returns results as bytes toward the UART transmit path.
- Sits in the reference-clock domain between the RX synchroniser output, the register file, the ALU/clock-gate and the TX FIFO.

Parameters:
- DATA_WIDTH, 8, byte width of RX/TX data and register-file data.
- ADDR_WIDTH, 4, register-file address width; address byte truncated to [ADDR_WIDTH-1:0].
- FUN_WIDTH, 4, ALU function select width; taken from byte [FUN_WIDTH-1:0].
- ALU_OUT_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH.

Ports:
- CLK  in  1  reference clock
- RST  in  1  reset, asynchronous, active-high
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  single-cycle pulse, RX_P_DATA valid
- RF_WR_EN  out  1  register-file write strobe, 1 cycle
- RF_RD_EN  out  1  register-file read strobe, 1 cycle
- RF_ADDR  out  ADDR_WIDTH  register-file address
- RF_WR_DATA  out  DATA_WIDTH  write data
- RF_RD_DATA  in  DATA_WIDTH  read data
- RF_RD_DATA_VLD  in  1  read data valid pulse
- ALU_EN  out  1  ALU start strobe, 1 cycle
- ALU_FUN  out  FUN_WIDTH  ALU function
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid pulse
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
- TX_D_VLD  out  1  TX byte valid
- TX_READY  in  1  TX FIFO can accept; transfer when TX_D_VLD && TX_READY
- CMD_ERR  out  1  1-cycle pulse: unknown command or dropped byte

Behaviour:
- Reset state: all outputs 0; state IDLE.
- All outputs are registered. Strobes are asserted the cycle after the RX_D_VLD that completes the field.
- Commands (first byte in IDLE):
  - 0xAA write: addr byte, data byte
  - 0xBB read: addr byte
  - 0xCC ALU-with-operands: OP_A, OP_B, FUN
  - 0xDD ALU-no-operands: FUN
- Any other byte in IDLE: CMD_ERR pulse, stay in IDLE.
- States and transitions:
  - IDLE -> WR_ADDR / RD_ADDR / OPA / FUN, selected by command byte.
  - WR_ADDR: on byte, latch RF_ADDR -> WR_DATA.
  - WR_DATA: on byte, RF_WR_DATA=byte, RF_WR_EN=1 for 1 cycle -> IDLE.
  - RD_ADDR: on byte, RF_ADDR=byte, RF_RD_EN=1 for 1 cycle -> RD_WAIT.
  - RD_WAIT: on RF_RD_DATA_VLD, capture data -> TX_RD.
  - TX_RD: TX_D_VLD=1 with captured byte, held stable until TX_READY -> IDLE.
  - OPA: on byte, write to address 0 (RF_WR_EN pulse) -> OPB.
  - OPB: on byte, write to address 1 -> FUN.
  - FUN: CLK_GATE_EN=1; on byte, ALU_FUN=byte[FUN_WIDTH-1:0], ALU_EN pulse -> ALU_WAIT.
  - ALU_WAIT: CLK_GATE_EN=1; on ALU_OUT_VLD, capture the 16-bit result -> TX_LO.
  - TX_LO: send result[7:0] -> TX_HI after handshake.
  - TX_HI: send result[15:8] -> IDLE after handshake.
- CLK_GATE_EN deasserts on the cycle of leaving ALU_WAIT.
- RX_D_VLD while in RD_WAIT, ALU_WAIT or any TX state: byte dropped, CMD_ERR pulse, state unchanged.
- TX_READY low: TX_D_VLD and TX_P_DATA hold; no timeout.
- RF_RD_DATA_VLD or ALU_OUT_VLD when not awaited: ignored.
- RST mid-command: immediate return to IDLE; pending strobes and TX_D_VLD cleared; partial command discarded.

Decomposition:
- Shared package holds:
  - command codes CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD
  - OPA_ADDR=0, OPB_ADDR=1
  - state encoding enum
- One sub-module: uart_tx_byte_sender. It is the holding register plus valid/ready handshake for TX_P_DATA/TX_D_VLD, with a "sent" pulse back to the FSM.

Test Plan:
- Reset, then bytes 0xAA,0x05,0x8F -> one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x8F; no TX activity.
- 0xBB,0x05; model returns 0x8F two cycles after RF_RD_EN -> one TX byte 0x8F; then IDLE.
- 0xCC,0x01,0x02,0x00; ALU model adds -> writes (0,0x01),(1,0x02); ALU_FUN=0, ALU_EN pulse; CLK_GATE_EN high FUN..ALU_WAIT; TX bytes 0x03 then 0x00.
- 0xDD,0x0C with TX_READY low 20 cycles, ALU_OUT=0x1234 -> TX_P_DATA=0x34 held stable 20 cycles, then 0x12.
- Byte 0x55 in IDLE, and extra byte during ALU_WAIT -> CMD_ERR pulse each; no RF/ALU strobes; the following 0xAA,0x05,0x8F executes normally.
- RST pulse after 0xCC,0x01 -> outputs 0, IDLE; next 0xBB,0x05 reads correctly.

Source files
------------

// File: rtl/uart_cmd_responder_pkg.sv
// rtl/uart_cmd_responder_pkg.sv - command codes, operand addresses and FSM states
package uart_cmd_responder_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_RD,
        ST_OPA,
        ST_OPB,
        ST_FUN,
        ST_ALU_WAIT,
        ST_TX_LO,
        ST_TX_HI
    } state_t;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// rtl/uart_cmd_responder_if.sv - RX, register-file, ALU and TX signals of the responder
interface uart_cmd_responder_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    RX_P_DATA;
    logic                     RX_D_VLD;
    logic                     RF_WR_EN;
    logic                     RF_RD_EN;
    logic [ADDR_WIDTH-1:0]    RF_ADDR;
    logic [DATA_WIDTH-1:0]    RF_WR_DATA;
    logic [DATA_WIDTH-1:0]    RF_RD_DATA;
    logic                     RF_RD_DATA_VLD;
    logic                     ALU_EN;
    logic [FUN_WIDTH-1:0]     ALU_FUN;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VLD;
    logic                     CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]    TX_P_DATA;
    logic                     TX_D_VLD;
    logic                     TX_READY;
    logic                     CMD_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, TX_READY,
        output RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, TX_READY,
        input  RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD, CMD_ERR
    );

endinterface

// File: rtl/uart_tx_byte_sender.sv
// rtl/uart_tx_byte_sender.sv - TX holding register with valid/ready handshake and sent pulse
module uart_tx_byte_sender #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  sent
);

    assign sent = tvalid && tready;

    // A load in the same cycle as a completed transfer chains the next byte without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata  <= '0;
            tvalid <= 1'b0;
        end else if (load) begin
            tdata  <= load_data;
            tvalid <= 1'b1;
        end else if (sent) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - UART command parser driving register file, ALU and TX bytes
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 16
) (
    input logic                  CLK,
    input logic                  RST,
    uart_cmd_responder_if.master bus
);

    state_t                state, state_nxt;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  alu_en_q, alu_en_d;
    logic                  gate_q, gate_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]  fun_q, fun_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] tx_load_data;
    logic                  tx_sent;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;

    uart_tx_byte_sender #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
        .clk       (CLK),
        .rst       (RST),
        .load      (tx_load),
        .load_data (tx_load_data),
        .tdata     (tx_data),
        .tvalid    (tx_valid),
        .tready    (bus.TX_READY),
        .sent      (tx_sent)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            gate_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            fun_q     <= '0;
            hi_q      <= '0;
        end else begin
            state     <= state_nxt;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            gate_q    <= gate_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            fun_q     <= fun_d;
            hi_q      <= hi_d;
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        alu_en_d     = 1'b0;
        err_d        = 1'b0;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        fun_d        = fun_q;
        hi_d         = hi_q;
        tx_load      = 1'b0;
        tx_load_data = '0;
        case (state)
            ST_IDLE: begin
                if (bus.RX_D_VLD) begin
                    case (bus.RX_P_DATA)
                        DATA_WIDTH'(CMD_RF_WR):   state_nxt = ST_WR_ADDR;
                        DATA_WIDTH'(CMD_RF_RD):   state_nxt = ST_RD_ADDR;
                        DATA_WIDTH'(CMD_ALU_OP):  state_nxt = ST_OPA;
                        DATA_WIDTH'(CMD_ALU_NOP): state_nxt = ST_FUN;
                        default:                  err_d     = 1'b1;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d    = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nxt = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d    = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                err_d = bus.RX_D_VLD;
                if (bus.RF_RD_DATA_VLD) begin
                    tx_load      = 1'b1;
                    tx_load_data = bus.RF_RD_DATA;
                    state_nxt    = ST_TX_RD;
                end
            end
            ST_TX_RD: begin
                err_d = bus.RX_D_VLD;
                if (tx_sent) state_nxt = ST_IDLE;
            end
            ST_OPA: begin
                if (bus.RX_D_VLD) begin
                    addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_nxt = ST_OPB;
                end
            end
            ST_OPB: begin
                if (bus.RX_D_VLD) begin
                    addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_nxt = ST_FUN;
                end
            end
            ST_FUN: begin
                if (bus.RX_D_VLD) begin
                    fun_d     = bus.RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_nxt = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                err_d = bus.RX_D_VLD;
                // Low byte goes straight to the sender; high byte waits its turn in hi_q.
                if (bus.ALU_OUT_VLD) begin
                    hi_d         = bus.ALU_OUT[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
                    tx_load      = 1'b1;
                    tx_load_data = bus.ALU_OUT[DATA_WIDTH-1:0];
                    state_nxt    = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                err_d = bus.RX_D_VLD;
                if (tx_sent) begin
                    tx_load      = 1'b1;
                    tx_load_data = hi_q;
                    state_nxt    = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                err_d = bus.RX_D_VLD;
                if (tx_sent) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        gate_d = (state_nxt == ST_FUN) || (state_nxt == ST_ALU_WAIT);
    end

    assign bus.RF_WR_EN    = wr_en_q;
    assign bus.RF_RD_EN    = rd_en_q;
    assign bus.RF_ADDR     = addr_q;
    assign bus.RF_WR_DATA  = wr_data_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.ALU_FUN     = fun_q;
    assign bus.CLK_GATE_EN = gate_q;
    assign bus.CMD_ERR     = err_q;
    assign bus.TX_P_DATA   = tx_data;
    assign bus.TX_D_VLD    = tx_valid;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - scoreboard bench for uart_cmd_responder
module tb_uart_cmd_responder;
    import uart_cmd_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_responder_if bus ();

    uart_cmd_responder dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [3:0] rd_q[$];
    logic [3:0] alu_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] err_q[$];

    logic [7:0] model_mem[16];
    logic [7:0] env_mem[16];

    int checks;
    int failures;
    int timeouts;
    bit done;
    bit hold_low;
    int alu_lat;
    int spur_req;
    int spur_done;

    int         r_kind;
    logic [7:0] r_a, r_b, r_f;

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            4'd5:    return {8'h00, a ^ b};
            4'd12:   return {a, b};
            default: return {b, a};
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge clk); #1;
        bus.RX_D_VLD  = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (tx_q.size() != 0 && i < 500) begin
            @(posedge clk);
            i++;
        end
        if (tx_q.size() != 0) begin
            timeouts++;
            $display("FAIL tx_drain_timeout pending=%0d required=0", tx_q.size());
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a[3:0];
        w.data = d;
        wr_q.push_back(w);
        model_mem[a[3:0]] = d;
        send_byte(CMD_RF_WR);
        send_byte(a);
        send_byte(d);
    endtask

    task automatic do_read(input logic [7:0] a);
        rd_q.push_back(a[3:0]);
        tx_q.push_back(model_mem[a[3:0]]);
        send_byte(CMD_RF_RD);
        send_byte(a);
        wait_drain();
    endtask

    task automatic push_alu(input logic [7:0] f);
        logic [15:0] res;
        res = alu_ref(model_mem[0], model_mem[1], f[3:0]);
        alu_q.push_back(f[3:0]);
        tx_q.push_back(res[7:0]);
        tx_q.push_back(res[15:8]);
    endtask

    task automatic do_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        wr_t w;
        w.addr = 4'd0; w.data = a; wr_q.push_back(w);
        w.addr = 4'd1; w.data = b; wr_q.push_back(w);
        model_mem[0] = a;
        model_mem[1] = b;
        push_alu(f);
        send_byte(CMD_ALU_OP);
        send_byte(a);
        send_byte(b);
        send_byte(f);
        wait_drain();
    endtask

    task automatic start_nop(input logic [7:0] f);
        push_alu(f);
        send_byte(CMD_ALU_NOP);
        send_byte(f);
    endtask

    task automatic do_bad(input logic [7:0] b);
        err_q.push_back(b);
        send_byte(b);
    endtask

    // Stimulus
    initial begin
        wr_t w;
        int i;
        checks = 0; failures = 0; timeouts = 0; done = 0; hold_low = 0;
        alu_lat = 2; spur_req = 0;
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD  = 1'b0;
        foreach (model_mem[k]) model_mem[k] = 8'h00;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_write(8'h05, 8'h8F);
        do_read(8'h05);
        do_alu(8'h01, 8'h02, 8'h00);

        do_write(8'h00, 8'h12);
        do_write(8'h01, 8'h34);
        hold_low = 1'b1;
        start_nop(8'h0C);
        i = 0;
        while (!bus.TX_D_VLD && i < 100) begin
            @(posedge clk);
            i++;
        end
        if (!bus.TX_D_VLD) begin
            timeouts++;
            $display("FAIL tx_valid_timeout actual=0 required=1");
        end
        repeat (20) @(posedge clk);
        hold_low = 1'b0;
        wait_drain();

        do_bad(8'h55);
        alu_lat = 12;
        start_nop(8'h03);
        do_bad(CMD_RF_WR);
        wait_drain();
        alu_lat = 2;
        do_write(8'h05, 8'h8F);

        w.addr = 4'd0; w.data = 8'h01; wr_q.push_back(w);
        model_mem[0] = 8'h01;
        send_byte(CMD_ALU_OP);
        send_byte(8'h01);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        do_read(8'h05);

        for (int n = 0; n < 40; n++) begin
            r_kind  = $urandom_range(0, 5);
            r_a     = 8'($urandom);
            r_b     = 8'($urandom);
            r_f     = 8'($urandom);
            alu_lat = $urandom_range(1, 4);
            case (r_kind)
                0: do_write(r_a, r_b);
                1: do_read(r_a);
                2: do_alu(r_a, r_b, (r_f[0]) ? {4'h0, 4'($urandom_range(0, 5))} : r_f);
                3: begin start_nop(r_f); wait_drain(); end
                4: begin
                    while (r_a == CMD_RF_WR || r_a == CMD_RF_RD || r_a == CMD_ALU_OP || r_a == CMD_ALU_NOP)
                        r_a = 8'($urandom);
                    do_bad(r_a);
                end
                default: begin
                    spur_req++;
                    repeat (3) @(posedge clk);
                end
            endcase
        end
        wait_drain();
        repeat (6) @(posedge clk);
        done = 1'b1;
    end

    // Register file and ALU environment; also serves stray valid pulses while the DUT is idle.
    initial begin
        int         rd_t, alu_t;
        logic [3:0]  rd_a;
        logic [15:0] alu_r;
        rd_t = 0; alu_t = 0; rd_a = '0; alu_r = '0; spur_done = 0;
        bus.RF_RD_DATA = '0; bus.RF_RD_DATA_VLD = 1'b0;
        bus.ALU_OUT = '0; bus.ALU_OUT_VLD = 1'b0;
        foreach (env_mem[k]) env_mem[k] = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.RF_WR_EN) env_mem[bus.RF_ADDR] = bus.RF_WR_DATA;
            if (bus.RF_RD_EN) begin rd_t = 2; rd_a = bus.RF_ADDR; end
            if (bus.ALU_EN) begin
                alu_t = alu_lat;
                alu_r = alu_ref(env_mem[0], env_mem[1], bus.ALU_FUN);
            end
            @(posedge clk); #1;
            bus.RF_RD_DATA_VLD = 1'b0;
            bus.ALU_OUT_VLD    = 1'b0;
            if (rd_t > 0) begin
                rd_t--;
                if (rd_t == 0) begin
                    bus.RF_RD_DATA     = env_mem[rd_a];
                    bus.RF_RD_DATA_VLD = 1'b1;
                end
            end
            if (alu_t > 0) begin
                alu_t--;
                if (alu_t == 0) begin
                    bus.ALU_OUT     = alu_r;
                    bus.ALU_OUT_VLD = 1'b1;
                end
            end else if (rd_t == 0 && spur_done != spur_req) begin
                spur_done++;
                bus.RF_RD_DATA     = 8'($urandom);
                bus.RF_RD_DATA_VLD = 1'b1;
                bus.ALU_OUT        = 16'($urandom);
                bus.ALU_OUT_VLD    = 1'b1;
            end
        end
    end

    initial begin
        bus.TX_READY = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.TX_READY = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard
    wr_t        m_w;
    logic       pv, pr;
    logic [7:0] pd;
    initial begin
        pv = 1'b0; pr = 1'b0; pd = '0;
        while (!done) begin
            @(negedge clk);
            if (rst) begin
                check("reset_outputs",
                      32'({bus.RF_WR_EN, bus.RF_RD_EN, bus.RF_ADDR, bus.RF_WR_DATA, bus.ALU_EN,
                           bus.ALU_FUN, bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR}), 0);
                pv = 1'b0;
            end else begin
                if (bus.RF_WR_EN) begin
                    check("rf_wr_expected", 32'(wr_q.size() != 0), 1);
                    if (wr_q.size() != 0) begin
                        m_w = wr_q.pop_front();
                        check("rf_wr_addr", 32'(bus.RF_ADDR), 32'(m_w.addr));
                        check("rf_wr_data", 32'(bus.RF_WR_DATA), 32'(m_w.data));
                    end
                end
                if (bus.RF_RD_EN) begin
                    check("rf_rd_expected", 32'(rd_q.size() != 0), 1);
                    if (rd_q.size() != 0) check("rf_rd_addr", 32'(bus.RF_ADDR), 32'(rd_q.pop_front()));
                end
                if (bus.ALU_EN) begin
                    check("alu_en_expected", 32'(alu_q.size() != 0), 1);
                    if (alu_q.size() != 0) check("alu_fun", 32'(bus.ALU_FUN), 32'(alu_q.pop_front()));
                    check("clk_gate_at_alu_en", 32'(bus.CLK_GATE_EN), 1);
                end
                if (bus.CMD_ERR) begin
                    check("cmd_err_expected", 32'(err_q.size() != 0), 1);
                    if (err_q.size() != 0) void'(err_q.pop_front());
                end
                if (bus.TX_D_VLD) check("clk_gate_during_tx", 32'(bus.CLK_GATE_EN), 0);
                if (pv && !pr) begin
                    check("tx_hold_valid", 32'(bus.TX_D_VLD), 1);
                    check("tx_hold_data", 32'(bus.TX_P_DATA), 32'(pd));
                end
                if (bus.TX_D_VLD && bus.TX_READY) begin
                    check("tx_expected", 32'(tx_q.size() != 0), 1);
                    if (tx_q.size() != 0) check("tx_byte", 32'(bus.TX_P_DATA), 32'(tx_q.pop_front()));
                end
                pv = bus.TX_D_VLD;
                pr = bus.TX_READY;
                pd = bus.TX_P_DATA;
            end
        end
        check("wr_q_empty", 32'(wr_q.size()), 0);
        check("rd_q_empty", 32'(rd_q.size()), 0);
        check("alu_q_empty", 32'(alu_q.size()), 0);
        check("tx_q_empty", 32'(tx_q.size()), 0);
        check("err_q_empty", 32'(err_q.size()), 0);
        check("timeouts", 32'(timeouts), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
